rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: ALU result path and memory-load path.
- Keeps a per-register busy scoreboard so the decode stage can stall on read-after-write and write-after-write hazards.
- Sits between the execute/memory stages and the 8x8 register file.
- Drives the register file's we/waddr/wdata directly from registered outputs.

Parameters:
- NREGS, 8, number of architectural registers.
- AW, 3, register address width (log2 NREGS).
- DW, 8, data width.

Ports:
- clk  in  1  single clock, rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_waddr  in  AW  ALU destination register.
- alu_wdata  in  DW  ALU result.
- alu_ready  out  1  ALU request granted this cycle.
- mem_valid  in  1  load writeback request.
- mem_waddr  in  AW  load destination register.
- mem_wdata  in  DW  load data.
- mem_ready  out  1  load request granted this cycle.
- iss_valid  in  1  decode issues an instruction that writes iss_rd.
- iss_rd  in  AW  destination register of the issuing instruction.
- iss_ready  out  1  issue accepted (destination not busy).
- rs1, rs2  in  AW  source registers of the decoding instruction.
- rs1_busy, rs2_busy  out  1  source register has a pending write.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  AW  register file write address (registered).
- rf_wdata  out  DW  register file write data (registered).
- busy_vec  out  NREGS  scoreboard state, bit i = register i pending.

Behaviour:
- Reset (areset_n low, async):
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, last_grant=ALU.
  - alu_ready, mem_ready and iss_ready are forced 0 while areset_n is low.
  - Reset mid-operation drops any in-flight write and clears all busy bits; requesters must re-present.
- Handshake:
  - Requesters hold valid, addr and data stable until ready.
  - Transfer occurs at a rising edge where valid&&ready.
  - Ready is combinational from the valids and last_grant; no ready-to-valid dependency.
- Arbitration (round-robin):
  - Only one valid: grant it.
  - Both valid: grant the requester that was not last_grant.
  - last_grant updates only on a completed transfer.
  - Neither requester waits more than one transfer.
- Write latency:
  - Transfer at edge E: rf_we=1, rf_waddr and rf_wdata hold the granted values for the cycle after E.
  - The register file commits at edge E+1.
  - No transfer at E: rf_we=0 for the next cycle; waddr/wdata hold their previous values.
  - Throughput is one write per cycle.
- Scoreboard:
  - Set: at an edge with iss_valid&&iss_ready, busy[iss_rd] is set.
  - Clear: at an edge with rf_we=1, busy[rf_waddr] is cleared. Clearing happens at commit, not at grant, so no cycle exists where busy=0 but the register file is stale.
  - Same register set and cleared at one edge: set wins (newer producer outstanding).
  - iss_ready = ~busy[iss_rd]; write-after-write issue stalls until the earlier write commits.
  - rs1_busy = busy[rs1], rs2_busy = busy[rs2], combinational from state only (no bypass).
  - A writeback to a non-busy register is legal: it writes the register file and leaves busy at 0.
- Ordering: writebacks to different registers commit in grant order. Same-register ordering is guaranteed by the iss_ready stall.
- No state machine beyond last_grant and the scoreboard; all state in flops on clk/areset_n.

Decomposition:
- Shared package (cpu_pkg):
  - AW, DW, NREGS constants.
  - enum grant_t {GNT_ALU, GNT_MEM}.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], advance, clk, areset_n.
  - Outputs: gnt[1:0] (one-hot or zero).
  - Reused later for memory-port sharing.
- Scoreboard and write register stay in rf_wb_arbiter.

Test Plan:
- Reset: assert areset_n=0 mid-transfer with busy_vec=8'h0F → rf_we=0, busy_vec=0, all readies 0 immediately (async), readies resume after release.
- Single write: issue rd=3, then alu_valid with waddr=3, wdata=8'hA5 → busy_vec[3]=1; alu_ready=1; next cycle rf_we=1, waddr=3, wdata=A5; after that edge busy_vec[3]=0 and rs1=3 gives rs1_busy=0.
- Contention: alu and mem valid every cycle for 4 cycles, last_grant=ALU at start → grants MEM, ALU, MEM, ALU; rf_we high 4 consecutive cycles with matching addr/data.
- WAW stall: issue rd=5, then iss_valid rd=5 again → iss_ready=0 until the cycle after the rf_we commit to r5, then iss_ready=1.
- Set/clear collision: rf_we committing r2 at the same edge as a new issue to r2 (iss_ready=1 because busy[2] was already cleared, e.g. after a stray writeback) → busy_vec[2]=1 after the edge.
- Stray writeback: mem_valid waddr=7, wdata=8'h3C with busy_vec=0 → write occurs, busy_vec stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the writeback grant encoding.
package cpu_pkg;
  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;

  typedef enum logic {GNT_ALU = 1'b0, GNT_MEM = 1'b1} grant_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req[0]/gnt[0] is the ALU side, req[1]/gnt[1] the memory side.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       areset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  grant_t last_grant;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == GNT_ALU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      last_grant <= GNT_ALU;
    end else if (advance && (gnt != 2'b00)) begin
      last_grant <= gnt[1] ? GNT_MEM : GNT_ALU;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter between ALU and load writebacks, plus the
// per-register busy scoreboard that decode uses for RAW/WAW stalls.
module rf_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int NREGS = cpu_pkg::NREGS,
  parameter int AW    = cpu_pkg::AW,
  parameter int DW    = cpu_pkg::DW
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_waddr,
  input  logic [DW-1:0]    alu_wdata,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [AW-1:0]    mem_waddr,
  input  logic [DW-1:0]    mem_wdata,
  output logic             mem_ready,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_ready,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic [NREGS-1:0] busy_vec
);

  logic [1:0]       gnt;
  logic             xfer;
  logic             vld_p1;
  logic [AW-1:0]    waddr_p1;
  logic [DW-1:0]    wdata_p1;
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;

  rr_arb2 u_arb (
    .clk      (clk),
    .areset_n (areset_n),
    .req      ({mem_valid, alu_valid}),
    .advance  (xfer),
    .gnt      (gnt)
  );

  // Readies are held low for the whole reset window, not just until the next edge.
  assign alu_ready = gnt[0] & areset_n;
  assign mem_ready = gnt[1] & areset_n;
  assign xfer      = alu_ready | mem_ready;

  assign iss_ready = areset_n & ~busy_q[iss_rd];
  assign rs1_busy  = busy_q[rs1];
  assign rs2_busy  = busy_q[rs2];

  // Stage p1: granted write presented to the register file
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= xfer;
      if (alu_ready) begin
        waddr_p1 <= alu_waddr;
        wdata_p1 <= alu_wdata;
      end else if (mem_ready) begin
        waddr_p1 <= mem_waddr;
        wdata_p1 <= mem_wdata;
      end
    end
  end

  assign rf_we    = vld_p1;
  assign rf_waddr = waddr_p1;
  assign rf_wdata = wdata_p1;

  // Clear on commit, then set on issue, so a new producer of the same register wins.
  always_comb begin
    busy_nxt = busy_q;
    if (vld_p1) busy_nxt[waddr_p1] = 1'b0;
    if (iss_valid && iss_ready) busy_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) busy_q <= '0;
    else           busy_q <= busy_nxt;
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a behavioural model.
module tb_rf_wb_arbiter;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       alu_valid, mem_valid, iss_valid;
  logic [2:0] alu_waddr, mem_waddr, iss_rd, rs1, rs2;
  logic [7:0] alu_wdata, mem_wdata;
  logic       alu_ready, mem_ready, iss_ready, rs1_busy, rs2_busy;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] busy_vec;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .areset_n(areset_n),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: set of pending registers, last winner, and the write seen by the RF next cycle.
  bit         m_busy [8];
  bit         m_last_mem;
  bit         m_we;
  logic [2:0] m_waddr;
  logic [7:0] m_wdata;
  bit         alu_taken, mem_taken;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_busy_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
    m_last_mem = 1'b0;
    m_we       = 1'b0;
    m_waddr    = '0;
    m_wdata    = '0;
    alu_taken  = 1'b0;
    mem_taken  = 1'b0;
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic step();
    bit ga, gm, iss_acc;
    #1;
    ga      = alu_valid && (!mem_valid || m_last_mem);
    gm      = mem_valid && (!alu_valid || !m_last_mem);
    iss_acc = iss_valid && !m_busy[iss_rd];
    check("alu_ready", 32'(alu_ready), 32'(ga));
    check("mem_ready", 32'(mem_ready), 32'(gm));
    check("iss_ready", 32'(iss_ready), 32'(!m_busy[iss_rd]));
    check("rs1_busy",  32'(rs1_busy),  32'(m_busy[rs1]));
    check("rs2_busy",  32'(rs2_busy),  32'(m_busy[rs2]));
    check("rf_we",     32'(rf_we),     32'(m_we));
    check("rf_waddr",  32'(rf_waddr),  32'(m_waddr));
    check("rf_wdata",  32'(rf_wdata),  32'(m_wdata));
    check("busy_vec",  32'(busy_vec),  32'(model_busy_vec()));
    @(posedge clk);
    if (m_we)    m_busy[m_waddr] = 1'b0;
    if (iss_acc) m_busy[iss_rd]  = 1'b1;
    m_we = ga || gm;
    if (ga) begin
      m_waddr = alu_waddr; m_wdata = alu_wdata; m_last_mem = 1'b0;
    end else if (gm) begin
      m_waddr = mem_waddr; m_wdata = mem_wdata; m_last_mem = 1'b1;
    end
    alu_taken = ga;
    mem_taken = gm;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; iss_valid = 0;
    alu_waddr = 0; mem_waddr = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    alu_wdata = 0; mem_wdata = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    areset_n  = 1'b0;
    alu_valid = 1; mem_valid = 1; iss_valid = 1;
    @(negedge clk);
    #1;
    check("rst_alu_ready", 32'(alu_ready), 32'(0));
    check("rst_mem_ready", 32'(mem_ready), 32'(0));
    check("rst_iss_ready", 32'(iss_ready), 32'(0));
    check("rst_rf_we",     32'(rf_we),     32'(0));
    check("rst_busy_vec",  32'(busy_vec),  32'(0));
    @(negedge clk);
    areset_n = 1'b1;
    idle_inputs();

    // Single write through the ALU to a freshly issued register
    iss_valid = 1; iss_rd = 3; rs1 = 3;
    step();
    iss_valid = 0; alu_valid = 1; alu_waddr = 3; alu_wdata = 8'hA5;
    step();
    alu_valid = 0;
    step();
    step();
    check("single_rs1_clear", 32'(rs1_busy), 32'(0));

    // Contention: last winner was ALU, so MEM, ALU, MEM, ALU
    alu_valid = 1; alu_waddr = 1; alu_wdata = 8'h11;
    mem_valid = 1; mem_waddr = 2; mem_wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      check("contend_order", 32'(mem_taken), 32'((i % 2) == 0));
      if (alu_taken) begin alu_waddr = 3'(4 + i); alu_wdata = 8'(8'h40 + i); end
      if (mem_taken) begin mem_waddr = 3'(i);     mem_wdata = 8'(8'h80 + i); end
    end
    alu_valid = 0; mem_valid = 0;
    step();
    step();

    // Write-after-write stall on r5
    iss_valid = 1; iss_rd = 5;
    step();
    step();
    check("waw_stall", 32'(iss_ready), 32'(0));
    alu_valid = 1; alu_waddr = 5; alu_wdata = 8'h5A;
    step();
    alu_valid = 0;
    step();
    step();
    iss_valid = 0;
    step();

    // Stray writeback to r2 colliding with a fresh issue of r2
    mem_valid = 1; mem_waddr = 2; mem_wdata = 8'h77;
    step();
    mem_valid = 0; iss_valid = 1; iss_rd = 2;
    step();
    iss_valid = 0;
    #1;
    check("collision_set_wins", 32'(busy_vec[2]), 32'(1));
    @(negedge clk);

    // Stray writeback to r7 leaves it not busy
    mem_valid = 1; mem_waddr = 7; mem_wdata = 8'h3C;
    step();
    mem_valid = 0;
    step();
    step();
    check("stray_not_busy", 32'(busy_vec[7]), 32'(0));

    // Asynchronous reset in the middle of a write with r0..r3 pending
    areset_n = 0;
    #1 areset_n = 1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1; iss_rd = 3'(i);
      step();
    end
    iss_valid = 0; alu_valid = 1; alu_waddr = 6; alu_wdata = 8'hC3;
    step();
    check("pre_rst_busy", 32'(busy_vec), 32'(8'h0F));
    check("pre_rst_we",   32'(rf_we),    32'(1));
    iss_valid = 1; iss_rd = 6;
    #2 areset_n = 0;
    #1;
    check("mid_rst_rf_we",     32'(rf_we),     32'(0));
    check("mid_rst_busy",      32'(busy_vec),  32'(0));
    check("mid_rst_alu_ready", 32'(alu_ready), 32'(0));
    check("mid_rst_iss_ready", 32'(iss_ready), 32'(0));
    @(negedge clk);
    areset_n = 1;
    model_reset();
    iss_valid = 0;
    step();
    alu_valid = 0;
    step();

    // Randomized traffic with valid/addr/data held until granted
    for (int c = 0; c < 400; c++) begin
      if (!alu_valid || alu_taken) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_waddr = 3'($urandom); alu_wdata = 8'($urandom);
      end
      if (!mem_valid || mem_taken) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_waddr = 3'($urandom); mem_wdata = 8'($urandom);
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 3'($urandom);
      rs1       = 3'($urandom);
      rs2       = 3'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
